ifft_frame_sink: RTL and testbench

Consumer for the IFFT core's master data stream. It accepts inverse-FFT output beats over AXI-Stream, checks frame alignment against tlast, and buffers the real part of each beat. It then releases one audio sample per sample_tick toward the audio output path. It is the receiving counterpart of the IFFT feed interface and replaces the tied-high ready on the IFFT output channel.

---
 rtl/ifft_pkg.sv | 28 ++
 rtl/sync_fifo.sv | 61 ++++++
 rtl/ifft_frame_sink.sv | 183 ++++++++++++++++++
 tb/tb_ifft_frame_sink.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/ifft_pkg.sv
// -----------------------------------------------------------------------------
// ifft_pkg
// Shared types and constants for the IFFT output sink.
//   DATAWIDTH    : width of one IFFT output beat (imag in upper half, real in lower)
//   SAMPLE_WIDTH : width of one signed audio sample (half a beat)
//   sample_t     : signed audio sample
//   ifft_beat_t  : one IFFT beat split into its imaginary and real halves
//   sink_state_t : playback FSM states
// -----------------------------------------------------------------------------
package ifft_pkg;

   localparam int DATAWIDTH    = 48;
   localparam int SAMPLE_WIDTH = DATAWIDTH / 2;

   typedef logic signed [SAMPLE_WIDTH-1:0] sample_t;

   // "real" is a reserved word, so the real half is called re.
   typedef struct packed {
      sample_t imag;
      sample_t re;
   } ifft_beat_t;

   typedef enum logic {
      FILL = 1'b0,
      PLAY = 1'b1
   } sink_state_t;

endpackage

// File: rtl/sync_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with a show-ahead read port and an occupancy count.
// The caller guarantees no push when full and no pop when empty.
// Ports:
//   i_clk, i_reset : clock, asynchronous active-high reset (pointers/count only)
//   i_push, i_din  : write strobe and data
//   i_pop          : read strobe; o_dout already shows the head entry
//   o_dout         : head of the FIFO
//   o_count        : number of stored entries, 0..DEPTH
// -----------------------------------------------------------------------------
module sync_fifo #(
   parameter int WIDTH = 24,
   parameter int DEPTH = 512
) (
   input  logic                     i_clk,
   input  logic                     i_reset,
   input  logic                     i_push,
   input  logic [WIDTH-1:0]         i_din,
   input  logic                     i_pop,
   output logic [WIDTH-1:0]         o_dout,
   output logic [$clog2(DEPTH):0]   o_count
);
   import ifft_pkg::*;

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   // Storage carries no reset; only the pointers define what is valid.
   always_ff @(posedge i_clk) begin
      if (i_push) begin
         r_mem[r_wr_ptr] <= i_din;
      end
   end

   // DEPTH is a power of two, so the pointers wrap on their own.
   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (i_push) begin
            r_wr_ptr <= r_wr_ptr + 1'b1;
         end
         if (i_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
         end
         r_count <= r_count + CNT_W'(i_push) - CNT_W'(i_pop);
      end
   end

   assign o_dout  = r_mem[r_rd_ptr];
   assign o_count = r_count;

endmodule

// File: rtl/ifft_frame_sink.sv
// -----------------------------------------------------------------------------
// ifft_frame_sink
// Receives IFFT output beats over AXI-Stream, checks frame alignment against
// tlast, buffers the real half of each beat and plays one sample per
// sample_tick once the buffer has primed.
// Ports:
//   clk, reset           : clock, asynchronous active-high reset
//   s_tdata/s_tvalid/s_tready/s_tlast : IFFT output stream (sink side)
//   sample_tick          : one-cycle audio-rate strobe
//   sample_out           : signed audio sample, held between ticks
//   sample_valid         : one-cycle pulse when sample_out updates
//   frame_done           : one-cycle pulse after a tlast beat is accepted
//   err_tlast_missing    : sticky, last beat of a frame arrived without tlast
//   err_tlast_unexpected : sticky, tlast arrived before the last beat
//   underrun             : sticky, tick in PLAY with an empty buffer
//   err_clear            : clears the three sticky flags (a same-cycle set wins)
// -----------------------------------------------------------------------------
module ifft_frame_sink #(
   parameter int DATAWIDTH    = ifft_pkg::DATAWIDTH,
   parameter int SAMPLE_WIDTH = ifft_pkg::SAMPLE_WIDTH,
   parameter int FRAME_LEN    = 256,
   parameter int FIFO_DEPTH   = 512,
   parameter int PRIME_LEVEL  = 256
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic [DATAWIDTH-1:0]           s_tdata,
   input  logic                           s_tvalid,
   output logic                           s_tready,
   input  logic                           s_tlast,
   input  logic                           sample_tick,
   output logic signed [SAMPLE_WIDTH-1:0] sample_out,
   output logic                           sample_valid,
   output logic                           frame_done,
   output logic                           err_tlast_missing,
   output logic                           err_tlast_unexpected,
   output logic                           underrun,
   input  logic                           err_clear
);
   import ifft_pkg::*;

   localparam int BC_W  = $clog2(FRAME_LEN);
   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam logic [BC_W-1:0]  LAST_BEAT = BC_W'(FRAME_LEN - 1);
   localparam logic [CNT_W-1:0] PRIME_CNT = CNT_W'(PRIME_LEVEL);
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);

   sink_state_t r_state;
   sink_state_t w_state_next;

   logic [BC_W-1:0]         r_beat_cnt;
   logic                    r_tready;
   logic signed [SAMPLE_WIDTH-1:0] r_sample;
   logic                    r_sample_valid;
   logic                    r_frame_done;
   logic                    r_err_missing;
   logic                    r_err_unexp;
   logic                    r_underrun;

   logic                    w_accept;
   logic                    w_pop;
   logic                    w_empty;
   logic                    w_tick_play;
   logic                    w_underrun_evt;
   logic                    w_beat_last;
   logic                    w_missing_evt;
   logic                    w_unexp_evt;
   logic [CNT_W-1:0]        w_count;
   logic [CNT_W-1:0]        w_count_next;
   logic [SAMPLE_WIDTH-1:0] w_fifo_dout;
   logic                    w_unused_imag;

   // The imaginary half of each beat is intentionally dropped.
   assign w_unused_imag = ^s_tdata[DATAWIDTH-1:SAMPLE_WIDTH];

   assign w_accept       = s_tvalid && r_tready;
   assign w_empty        = (w_count == '0);
   assign w_tick_play    = sample_tick && (r_state == PLAY);
   assign w_pop          = w_tick_play && !w_empty;
   assign w_underrun_evt = w_tick_play && w_empty;
   assign w_beat_last    = (r_beat_cnt == LAST_BEAT);
   assign w_missing_evt  = w_accept && w_beat_last && !s_tlast;
   assign w_unexp_evt    = w_accept && s_tlast && !w_beat_last;
   assign w_count_next   = w_count + CNT_W'(w_accept) - CNT_W'(w_pop);

   sync_fifo #(
      .WIDTH (SAMPLE_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .i_clk   (clk),
      .i_reset (reset),
      .i_push  (w_accept),
      .i_din   (s_tdata[SAMPLE_WIDTH-1:0]),
      .i_pop   (w_pop),
      .o_dout  (w_fifo_dout),
      .o_count (w_count)
   );

   // Priming looks at the level after this cycle's push so a frame that
   // lands exactly on PRIME_LEVEL starts playback on the next cycle.
   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         FILL:    if (w_count_next >= PRIME_CNT) w_state_next = PLAY;
         PLAY:    if (w_underrun_evt)            w_state_next = FILL;
         default: w_state_next = FILL;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= FILL;
      end else begin
         r_state <= w_state_next;
      end
   end

   // Ready is registered from the post-update count: a pop never opens a
   // combinational path to ready, so a full FIFO refuses the beat that
   // arrives in the same cycle as the freeing pop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tready <= 1'b0;
      end else begin
         r_tready <= (w_count_next < FULL_CNT);
      end
   end

   // Frame checker: a missing tlast wraps the count so the next beat
   // re-anchors as beat 0.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_beat_cnt   <= '0;
         r_frame_done <= 1'b0;
      end else begin
         r_frame_done <= w_accept && s_tlast;
         if (w_accept) begin
            if (s_tlast || w_beat_last) begin
               r_beat_cnt <= '0;
            end else begin
               r_beat_cnt <= r_beat_cnt + 1'b1;
            end
         end
      end
   end

   // Playback output; an underrun emits a zero sample.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_sample       <= '0;
         r_sample_valid <= 1'b0;
      end else begin
         r_sample_valid <= w_tick_play;
         if (w_pop) begin
            r_sample <= w_fifo_dout;
         end else if (w_underrun_evt) begin
            r_sample <= '0;
         end
      end
   end

   // Sticky flags: a set event in the same cycle as err_clear wins.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_err_missing <= 1'b0;
         r_err_unexp   <= 1'b0;
         r_underrun    <= 1'b0;
      end else begin
         r_err_missing <= w_missing_evt  || (r_err_missing && !err_clear);
         r_err_unexp   <= w_unexp_evt    || (r_err_unexp   && !err_clear);
         r_underrun    <= w_underrun_evt || (r_underrun    && !err_clear);
      end
   end

   assign s_tready             = r_tready;
   assign sample_out           = r_sample;
   assign sample_valid         = r_sample_valid;
   assign frame_done           = r_frame_done;
   assign err_tlast_missing    = r_err_missing;
   assign err_tlast_unexpected = r_err_unexp;
   assign underrun             = r_underrun;

endmodule

// File: tb/tb_ifft_frame_sink.sv
// -----------------------------------------------------------------------------
// tb_ifft_frame_sink
// Directed bench for ifft_frame_sink with FRAME_LEN=8, FIFO_DEPTH=16,
// PRIME_LEVEL=8. Accepted beats push their real part onto a scoreboard queue;
// every sample_valid pops the queue and compares sample_out.
// -----------------------------------------------------------------------------
module tb_ifft_frame_sink;

   localparam int DW = 48;
   localparam int SW = 24;

   logic                 clk = 1'b0;
   logic                 reset;
   logic [DW-1:0]        s_tdata;
   logic                 s_tvalid;
   logic                 s_tready;
   logic                 s_tlast;
   logic                 sample_tick;
   logic signed [SW-1:0] sample_out;
   logic                 sample_valid;
   logic                 frame_done;
   logic                 err_tlast_missing;
   logic                 err_tlast_unexpected;
   logic                 underrun;
   logic                 err_clear;

   int n_cmp  = 0;
   int n_fail = 0;
   int n_fd   = 0;
   logic [SW-1:0] sb_q[$];

   ifft_frame_sink #(
      .DATAWIDTH    (DW),
      .SAMPLE_WIDTH (SW),
      .FRAME_LEN    (8),
      .FIFO_DEPTH   (16),
      .PRIME_LEVEL  (8)
   ) dut (
      .clk                  (clk),
      .reset                (reset),
      .s_tdata              (s_tdata),
      .s_tvalid             (s_tvalid),
      .s_tready             (s_tready),
      .s_tlast              (s_tlast),
      .sample_tick          (sample_tick),
      .sample_out           (sample_out),
      .sample_valid         (sample_valid),
      .frame_done           (frame_done),
      .err_tlast_missing    (err_tlast_missing),
      .err_tlast_unexpected (err_tlast_unexpected),
      .underrun             (underrun),
      .err_clear            (err_clear)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; outputs are sampled 1 time unit after the rising edge.
   task automatic step();
      logic [SW-1:0] exp_s;
      @(posedge clk);
      #1;
      if (frame_done) n_fd++;
      if (sample_valid) begin
         chk("sb_has_entry", 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            exp_s = sb_q.pop_front();
            chk("sample_out", 64'(sample_out), 64'(exp_s));
         end
      end
   endtask

   task automatic send_beat(input int re, input logic last);
      logic acc;
      acc = 1'b0;
      s_tdata  = {24'($urandom), 24'(re)};
      s_tvalid = 1'b1;
      s_tlast  = last;
      for (int i = 0; i < 40 && !acc; i++) begin
         acc = s_tready;
         step();
      end
      if (acc) sb_q.push_back(SW'(re));
      else chk("beat_accept_timeout", 64'(acc), 64'd1);
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
   endtask

   task automatic send_frame(input int base, input int n, input int last_at);
      for (int i = 0; i < n; i++) send_beat(base + i, (i + 1) == last_at);
   endtask

   task automatic tick_expect(input string tag, input logic exp_valid);
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk(tag, 64'(sample_valid), 64'(exp_valid));
   endtask

   task automatic do_reset();
      reset       = 1'b1;
      s_tvalid    = 1'b0;
      s_tlast     = 1'b0;
      sample_tick = 1'b0;
      err_clear   = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;
      sb_q.delete();
      step();
   endtask

   initial begin
      reset = 1'b1; s_tdata = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
      sample_tick = 1'b0; err_clear = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_tready",   64'(s_tready), 64'd0);
      chk("rst_sample",   64'(sample_out), 64'd0);
      chk("rst_valid",    64'(sample_valid), 64'd0);
      chk("rst_fdone",    64'(frame_done), 64'd0);
      chk("rst_missing",  64'(err_tlast_missing), 64'd0);
      chk("rst_unexp",    64'(err_tlast_unexpected), 64'd0);
      chk("rst_underrun", 64'(underrun), 64'd0);
      reset = 1'b0;
      step();
      chk("tready_after_release", 64'(s_tready), 64'd1);

      // 1: one aligned frame, then eight ticks
      n_fd = 0;
      send_frame(1, 8, 8);
      chk("t1_frame_done_count", 64'(n_fd), 64'd1);
      for (int i = 0; i < 8; i++) tick_expect("t1_valid_latency1", 1'b1);
      chk("t1_sb_drained", 64'(sb_q.size()), 64'd0);
      chk("t1_missing", 64'(err_tlast_missing), 64'd0);
      chk("t1_unexp",   64'(err_tlast_unexpected), 64'd0);
      chk("t1_underrun", 64'(underrun), 64'd0);

      // 2: fill to full, hold a 17th beat until a tick frees a slot
      do_reset();
      send_frame(1, 8, 8);
      send_frame(9, 8, 8);
      chk("t2_tready_full", 64'(s_tready), 64'd0);
      s_tdata = {24'h0, 24'd17}; s_tvalid = 1'b1; s_tlast = 1'b0;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_tready_held", 64'(s_tready), 64'd0);
      end
      sample_tick = 1'b1;
      step();
      sample_tick = 1'b0;
      chk("t2_tick_valid", 64'(sample_valid), 64'd1);
      chk("t2_tready_after_pop", 64'(s_tready), 64'd1);
      step();
      sb_q.push_back(SW'(17));
      s_tvalid = 1'b0;
      chk("t2_tready_full_again", 64'(s_tready), 64'd0);
      step();
      for (int i = 0; i < 16; i++) tick_expect("t2_drain_valid", 1'b1);
      chk("t2_sb_drained", 64'(sb_q.size()), 64'd0);
      chk("t2_no_underrun", 64'(underrun), 64'd0);

      // 3: early tlast, then a clean frame, then clear
      do_reset();
      send_frame(1, 5, 5);
      chk("t3_unexp_set", 64'(err_tlast_unexpected), 64'd1);
      send_frame(11, 8, 8);
      chk("t3_unexp_sticky", 64'(err_tlast_unexpected), 64'd1);
      chk("t3_no_missing", 64'(err_tlast_missing), 64'd0);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("t3_unexp_cleared", 64'(err_tlast_unexpected), 64'd0);

      // 4: missing tlast, then the next beat re-anchors as beat 0
      do_reset();
      send_frame(1, 7, 0);
      chk("t4_missing_before", 64'(err_tlast_missing), 64'd0);
      send_beat(8, 1'b0);
      chk("t4_missing_set", 64'(err_tlast_missing), 64'd1);
      err_clear = 1'b1;
      step();
      err_clear = 1'b0;
      chk("t4_missing_cleared", 64'(err_tlast_missing), 64'd0);
      send_frame(21, 8, 8);
      chk("t4_realigned_unexp", 64'(err_tlast_unexpected), 64'd0);
      chk("t4_realigned_missing", 64'(err_tlast_missing), 64'd0);

      // 5: underrun after draining, then FILL ignores ticks until reprimed
      do_reset();
      send_frame(31, 8, 8);
      for (int i = 0; i < 8; i++) tick_expect("t5_valid", 1'b1);
      sb_q.push_back('0);
      tick_expect("t5_underrun_valid", 1'b1);
      chk("t5_underrun_flag", 64'(underrun), 64'd1);
      tick_expect("t5_fill_ignores_tick", 1'b0);
      send_frame(51, 7, 0);
      tick_expect("t5_fill_7_ignores_tick", 1'b0);
      send_beat(58, 1'b1);
      tick_expect("t5_replay_valid", 1'b1);
      chk("t5_underrun_sticky", 64'(underrun), 64'd1);

      // 6: reset mid-frame with 10 samples buffered
      do_reset();
      send_frame(1, 8, 8);
      send_frame(9, 3, 0);
      tick_expect("t6_pre_valid", 1'b1);
      reset = 1'b1;
      #1;
      chk("t6_rst_tready",  64'(s_tready), 64'd0);
      chk("t6_rst_sample",  64'(sample_out), 64'd0);
      chk("t6_rst_valid",   64'(sample_valid), 64'd0);
      chk("t6_rst_fdone",   64'(frame_done), 64'd0);
      do_reset();
      send_frame(100, 8, 8);
      chk("t6_no_unexp",   64'(err_tlast_unexpected), 64'd0);
      chk("t6_no_missing", 64'(err_tlast_missing), 64'd0);
      for (int i = 0; i < 8; i++) tick_expect("t6_valid", 1'b1);
      sb_q.push_back('0);
      tick_expect("t6_empty_underrun_valid", 1'b1);
      chk("t6_fifo_was_emptied", 64'(underrun), 64'd1);
      chk("t6_sb_drained", 64'(sb_q.size()), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
